// File: rtl/teller_dispatch.sv
// Teller-side dispatcher: round-robin grants free tellers to waiting customers and
// emits an active-low leave strobe plus the ticket/teller being called.
module teller_dispatch #(
    parameter int N         = 3,
    parameter int PULSE_LEN = 2,
    parameter int GAP_LEN   = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [1:0]   Tcount,
    input  logic [2:0]   done_n,
    input  logic [N:0]   Pcount,
    input  logic         emptyFlag,
    output logic         leave_n,
    output logic         call_valid,
    output logic [1:0]   call_teller,
    output logic [N:0]   ticket,
    output logic [2:0]   busy,
    output logic [1:0]   dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int CW = 8;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    rr_ptr_q, rr_ptr_d;
    logic [2:0]    busy_q, busy_d;
    logic [N:0]    ticket_q, ticket_d;
    logic [1:0]    call_teller_q, call_teller_d;
    logic          leave_n_q, leave_n_d;
    logic          call_valid_q, call_valid_d;

    logic [2:0]    done_s1_q, done_s2_q, done_prev_q;
    logic [2:0]    done_fall;
    logic [2:0]    active;
    logic [2:0]    free;
    logic          eligible;
    logic          grant;
    logic          grant_found;
    logic [1:0]    grant_idx;
    logic [2:0]    grant_mask;

    // Falling edge of the synchronized button, one cycle after it reaches sync2.
    assign done_fall = done_prev_q & ~done_s2_q;

    always_comb begin
        active = 3'b000;
        case (Tcount)
            2'd1:    active = 3'b001;
            2'd2:    active = 3'b011;
            2'd3:    active = 3'b111;
            default: active = 3'b000;
        endcase
    end

    assign free     = active & ~busy_q;
    assign eligible = (|free) & ~emptyFlag & (Pcount != '0);

    // Rotate the free mask so bit 0 is the teller at rr_ptr, then take the lowest set bit.
    always_comb begin
        logic [2:0] rot;
        rot = 3'b000;
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        case (rr_ptr_q)
            2'd1:    rot = {free[0], free[2], free[1]};
            2'd2:    rot = {free[1], free[0], free[2]};
            default: rot = free;
        endcase
        if (rot[0]) begin
            grant_found = 1'b1;
            grant_idx   = rr_ptr_q;
        end else if (rot[1]) begin
            grant_found = 1'b1;
            grant_idx   = (rr_ptr_q == 2'd2) ? 2'd0 : rr_ptr_q + 2'd1;
        end else if (rot[2]) begin
            grant_found = 1'b1;
            grant_idx   = (rr_ptr_q == 2'd0) ? 2'd2 : rr_ptr_q - 2'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                if (eligible && grant_found) begin
                    grant   = 1'b1;
                    state_d = PULSE;
                    cnt_d   = '0;
                end
            end
            PULSE: begin
                if (cnt_q == CW'(PULSE_LEN - 1)) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == CW'(GAP_LEN - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        grant_mask    = grant ? (3'b001 << grant_idx) : 3'b000;
        busy_d        = ((busy_q & ~done_fall) | grant_mask) & active;
        ticket_d      = ticket_q;
        call_teller_d = call_teller_q;
        rr_ptr_d      = rr_ptr_q;
        if (grant) begin
            ticket_d      = ticket_q + 1'b1;
            call_teller_d = grant_idx;
            rr_ptr_d      = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
        end
        // Strobes are registered from the next state so they are glitch-free and start on the grant edge.
        leave_n_d    = (state_d != PULSE);
        call_valid_d = (state_d == PULSE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rr_ptr_q      <= 2'd0;
            busy_q        <= 3'b000;
            ticket_q      <= '0;
            call_teller_q <= 2'd0;
            leave_n_q     <= 1'b1;
            call_valid_q  <= 1'b0;
            done_s1_q     <= 3'b111;
            done_s2_q     <= 3'b111;
            done_prev_q   <= 3'b111;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rr_ptr_q      <= rr_ptr_d;
            busy_q        <= busy_d;
            ticket_q      <= ticket_d;
            call_teller_q <= call_teller_d;
            leave_n_q     <= leave_n_d;
            call_valid_q  <= call_valid_d;
            done_s1_q     <= done_n;
            done_s2_q     <= done_s1_q;
            done_prev_q   <= done_s2_q;
        end
    end

    assign leave_n     = leave_n_q;
    assign call_valid  = call_valid_q;
    assign call_teller = call_teller_q;
    assign ticket      = ticket_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_teller_dispatch.sv
// Bench for teller_dispatch: directed scenarios plus a randomized run, all checked
// every cycle against a timer/queue-based reference model of the dispatcher.
module tb_teller_dispatch;

    localparam int N         = 3;
    localparam int PULSE_LEN = 2;
    localparam int GAP_LEN   = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic [1:0]   Tcount;
    logic [2:0]   done_n;
    logic [N:0]   Pcount;
    logic         emptyFlag;
    logic         leave_n;
    logic         call_valid;
    logic [1:0]   call_teller;
    logic [N:0]   ticket;
    logic [2:0]   busy;
    logic [1:0]   dbg_state_o;

    teller_dispatch #(.N(N), .PULSE_LEN(PULSE_LEN), .GAP_LEN(GAP_LEN)) dut (
        .clock       (clock),
        .reset       (reset),
        .Tcount      (Tcount),
        .done_n      (done_n),
        .Pcount      (Pcount),
        .emptyFlag   (emptyFlag),
        .leave_n     (leave_n),
        .call_valid  (call_valid),
        .call_teller (call_teller),
        .ticket      (ticket),
        .busy        (busy),
        .dbg_state_o (dbg_state_o)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: a dispatch blocks arbitration for PULSE_LEN+GAP_LEN cycles.
    logic [2:0] m_busy;
    int         m_rr;
    logic [N:0] m_ticket;
    logic [1:0] m_teller;
    int         m_timer;
    logic [2:0] h1, h2, h3;

    logic [1:0] grants_q[$];
    int         fall_q[$];
    logic       last_leave = 1'b1;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy   = 3'b000;
        m_rr     = 0;
        m_ticket = '0;
        m_teller = 2'd0;
        m_timer  = 0;
        h1 = 3'b111;
        h2 = 3'b111;
        h3 = 3'b111;
    endtask

    task automatic model_edge();
        logic [2:0] fall, act, fr, gm;
        bit found;
        int g;
        if (!reset) begin
            model_reset();
            return;
        end
        fall = h3 & ~h2;
        act  = 3'((1 << Tcount) - 1);
        gm   = 3'b000;
        if (m_timer == 0) begin
            fr = act & ~m_busy;
            if (fr != 0 && !emptyFlag && Pcount != 0) begin
                found = 0;
                for (int k = 0; k < 3; k++) begin
                    g = (m_rr + k) % 3;
                    if (!found && fr[g]) begin
                        found    = 1;
                        gm       = 3'(1 << g);
                        m_teller = 2'(g);
                        m_rr     = (g + 1) % 3;
                    end
                end
                m_ticket = m_ticket + 1'b1;
                m_timer  = PULSE_LEN + GAP_LEN;
            end
        end else begin
            m_timer--;
        end
        m_busy = ((m_busy & ~fall) | gm) & act;
        h3 = h2;
        h2 = h1;
        h1 = done_n;
    endtask

    task automatic step();
        logic exp_leave;
        model_edge();
        @(posedge clock);
        #1;
        cyc++;
        exp_leave = !(m_timer > GAP_LEN);
        chk("leave_n", 8'(leave_n), 8'(exp_leave));
        chk("call_valid", 8'(call_valid), 8'(!exp_leave));
        chk("call_teller", 8'(call_teller), 8'(m_teller));
        chk("ticket", 8'(ticket), 8'(m_ticket));
        chk("busy", 8'(busy), 8'(m_busy));
        if (last_leave && !leave_n) begin
            grants_q.push_back(call_teller);
            fall_q.push_back(cyc);
        end
        last_leave = leave_n;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Pulse a set of done buttons low (mask bits = buttons pressed) for a few cycles.
    task automatic press(input logic [2:0] mask);
        done_n = ~mask;
        steps(3);
        done_n = 3'b111;
    endtask

    task automatic async_reset_check(input string tag);
        #2;
        reset = 1'b0;
        #1;
        chk({tag, "_leave_n"}, 8'(leave_n), 8'd1);
        chk({tag, "_call_valid"}, 8'(call_valid), 8'd0);
        chk({tag, "_ticket"}, 8'(ticket), 8'd0);
        chk({tag, "_busy"}, 8'(busy), 8'd0);
        chk({tag, "_state"}, 8'(dbg_state_o), 8'd0);
        model_reset();
        last_leave = 1'b1;
    endtask

    initial begin
        int low_seen;
        bit hit;
        reset     = 1'b0;
        Tcount    = 2'd1;
        Pcount    = 4'd2;
        emptyFlag = 1'b0;
        done_n    = 3'b111;
        model_reset();
        steps(3);
        chk("reset_leave_n", 8'(leave_n), 8'd1);
        chk("reset_ticket", 8'(ticket), 8'd0);
        chk("reset_busy", 8'(busy), 8'd0);

        // Single teller: one grant, then blocked until its done button falls.
        reset = 1'b1;
        step();
        chk("t2_first_leave", 8'(leave_n), 8'd0);
        chk("t2_first_ticket", 8'(ticket), 8'd1);
        chk("t2_first_busy", 8'(busy), 8'd1);
        steps(15);
        chk("t2_one_grant", 8'(grants_q.size()), 8'd1);
        press(3'b001);
        steps(15);
        chk("t2_two_grants", 8'(grants_q.size()), 8'd2);
        chk("t2_ticket2", 8'(ticket), 8'd2);

        // Mid-run asynchronous reset.
        async_reset_check("t1");
        steps(2);

        // Three tellers, all free: grants 0,1,2 spaced 7 cycles.
        grants_q.delete();
        fall_q.delete();
        Tcount = 2'd3;
        Pcount = 4'd5;
        reset  = 1'b1;
        steps(22);
        chk("t3_count", 8'(grants_q.size()), 8'd3);
        if (grants_q.size() == 3) begin
            chk("t3_g0", 8'(grants_q[0]), 8'd0);
            chk("t3_g1", 8'(grants_q[1]), 8'd1);
            chk("t3_g2", 8'(grants_q[2]), 8'd2);
            chk("t3_space01", 8'(fall_q[1] - fall_q[0]), 8'd7);
            chk("t3_space12", 8'(fall_q[2] - fall_q[1]), 8'd7);
        end
        chk("t3_busy", 8'(busy), 8'd7);

        // Tellers 0 and 1 finish together: re-granted 0 then 1.
        grants_q.delete();
        press(3'b011);
        steps(25);
        chk("t4_count", 8'(grants_q.size()), 8'd2);
        if (grants_q.size() == 2) begin
            chk("t4_g0", 8'(grants_q[0]), 8'd0);
            chk("t4_g1", 8'(grants_q[1]), 8'd1);
        end

        // Empty queue or zero occupancy: no strobe, but done still frees tellers.
        grants_q.delete();
        emptyFlag = 1'b1;
        steps(8);
        press(3'b101);
        steps(10);
        emptyFlag = 1'b0;
        Pcount    = 4'd0;
        press(3'b010);
        steps(10);
        low_seen = grants_q.size();
        chk("t5_no_strobe", 8'(low_seen), 8'd0);
        chk("t5_busy_clear", 8'(busy), 8'd0);

        // Randomized traffic, long enough for the ticket to wrap several times.
        for (int i = 0; i < 900; i++) begin
            if (i % 37 == 0) begin
                Tcount    = 2'($urandom_range(0, 3));
                Pcount    = 4'($urandom_range(0, 15));
                emptyFlag = ($urandom_range(0, 4) == 0);
            end
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, 5) == 0) done_n[b] = ~done_n[b];
            step();
        end

        // Reset during the first PULSE cycle.
        Tcount    = 2'd3;
        Pcount    = 4'd5;
        emptyFlag = 1'b0;
        done_n    = 3'b111;
        steps(4);
        press(3'b111);
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            step();
            if (!leave_n) hit = 1;
        end
        chk("t6_pulse_seen", 8'(hit), 8'd1);
        async_reset_check("t6");
        steps(3);
        reset = 1'b1;
        steps(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
